alu: RTL and testbench
======================

Name: alu

Overview:
- Transfer-triggered 32-bit ALU for the Periwinkle move-only CPU. The CPU writes operands and a function code through the ALU SPR window (SPRs 4–7, selected by a 2-bit input op) and reads results back through the same window (2-bit output op).
- The result is registered. It is accompanied by 5 status flags and a valid bit; the CPU copies the flags into STATUS whenever valid is high.

Parameters:
- WIDTH, 32, datapath width (fixed at 32; not meant to be overridden).
- FUNC_W, 4, width of the function code taken from i_data[3:0].

Ports:
- i_clk, in, 1, clock, rising edge.
- i_rst_n, in, 1, reset; asynchronous, active-low.
- i_input_op, in, 2, write target: 0=OPA, 1=OPB, 2=FUNC (launch), 3=CLEAR.
- i_data_valid, in, 1, qualifies a write this cycle.
- i_data, in, 32, write data.
- i_output_op, in, 2, read select: 0=RESULT, 1=RESULT_HI, 2=OPA readback, 3=OPB readback.
- i_result_empty, in, 1, the CPU is consuming the result this cycle.
- o_result_valid, out, 1, a computed result is pending.
- o_result, out, 32, combinational mux of registered state selected by i_output_op.
- o_result_flags, out, 5, registered flags of the last computation.

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - opa, opb, res_lo, res_hi, flags and valid are all 0.
  - Therefore o_result=0, o_result_flags=0, o_result_valid=0.
- All state updates on the rising i_clk edge, and only when i_data_valid=1.
- Input ops:
  - op0: opa<=i_data.
  - op1: opb<=i_data.
  - op2: compute func=i_data[3:0] on current opa/opb. res_lo, res_hi and flags are loaded and valid<=1 at that edge (latency 1 cycle).
  - op3: clear opa, opb, res_lo, res_hi, flags and valid to 0.
- Functions, A=opa, B=opb, unsigned arithmetic modulo 2^32 unless stated:
  - 0 ADD: A+B; res_hi = carry-out (0/1).
  - 1 SUB: A-B; res_hi = borrow.
  - 2 AND, 3 OR, 4 XOR.
  - 5 NOT: ~A.
  - 6 SHL: A<<B[4:0].
  - 7 SHR: logical right shift of A by B[4:0].
  - 8 ASR: arithmetic right shift of A by B[4:0].
  - 9 MUL: 64-bit unsigned A*B; res_lo = low word, res_hi = high word.
  - 10–15: res_lo=0, res_hi=0 (flags computed normally, so Z=1).
  - res_hi=0 for every function not listed with a res_hi value above.
- Flags, bit index:
  - 0 Z: res_lo==0.
  - 1 N: res_lo[31].
  - 2 C: carry (ADD), borrow (SUB), last bit shifted out (SHL/SHR/ASR), res_hi!=0 (MUL); 0 otherwise.
  - 3 V: signed overflow for ADD/SUB; 0 otherwise.
  - 4 E: A==B.
- Output mux (combinational, no latency):
  - 0 → res_lo
  - 1 → res_hi
  - 2 → opa
  - 3 → opb
- Consume:
  - i_result_empty=1 with i_output_op 0 or 1 clears valid at the next edge.
  - res_lo, res_hi and flags are retained after a consume.
  - i_result_empty with output op 2/3 has no effect.
- Simultaneous events:
  - A launch (op2) in the same cycle as a consume: the launch wins, valid=1 with the new result.
  - CLEAR in the same cycle as a consume: the result is cleared.
- Shift counts ≥32 are impossible because only B[4:0] is used.
- A second launch without a consume overwrites the result; valid stays 1.

Decomposition:
- alu_pkg holds:
  - input-op constants (OP_OPA, OP_OPB, OP_FUNC, OP_CLEAR);
  - output-op constants (OUT_RES, OUT_HI, OUT_OPA, OUT_OPB);
  - function-code constants (F_ADD..F_MUL);
  - flag bit indices (FLG_Z, FLG_N, FLG_C, FLG_V, FLG_E).
- One sub-module, alu_func: a purely combinational function unit (opa, opb, func → lo, hi, flags). The top level holds the registers, the valid logic and the output mux.

Test Plan:
- ADD: write OPA=0xFFFFFFFF, OPB=1, FUNC=0 → next cycle valid=1, RESULT=0, RESULT_HI=1, flags Z=1, C=1, N=0, V=0, E=0.
- SUB signed overflow: OPA=0x80000000, OPB=1, FUNC=1 → RESULT=0x7FFFFFFF, V=1, C=0, N=0; then OPB=0x80000000, FUNC=1 → RESULT=0, Z=1, E=1.
- MUL: OPA=0x10000, OPB=0x10000, FUNC=9 → RESULT=0, RESULT_HI=1, Z=1, C=1.
- Shifts: OPA=0x80000001, OPB=0x21 (shift 1), FUNC=8 → RESULT=0xC0000000, C=1, N=1; FUNC=6 → RESULT=2, C=1.
- Handshake:
  - Read RESULT with i_result_empty=1 → valid=0 next cycle, RESULT value still readable.
  - Launch and consume in the same cycle → valid stays 1.
  - CLEAR → all outputs 0.
- Reset mid-operation: assert i_rst_n=0 asynchronously while valid=1 → valid, flags and all readbacks 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the Periwinkle ALU: SPR window op codes, function codes and flag
// bit positions.
package alu_pkg;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned FUNC_W = 4;
    localparam int unsigned FLAG_W = 5;

    localparam logic [1:0] OP_OPA   = 2'd0;
    localparam logic [1:0] OP_OPB   = 2'd1;
    localparam logic [1:0] OP_FUNC  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    localparam logic [1:0] OUT_RES = 2'd0;
    localparam logic [1:0] OUT_HI  = 2'd1;
    localparam logic [1:0] OUT_OPA = 2'd2;
    localparam logic [1:0] OUT_OPB = 2'd3;

    localparam logic [FUNC_W-1:0] F_ADD = 4'd0;
    localparam logic [FUNC_W-1:0] F_SUB = 4'd1;
    localparam logic [FUNC_W-1:0] F_AND = 4'd2;
    localparam logic [FUNC_W-1:0] F_OR  = 4'd3;
    localparam logic [FUNC_W-1:0] F_XOR = 4'd4;
    localparam logic [FUNC_W-1:0] F_NOT = 4'd5;
    localparam logic [FUNC_W-1:0] F_SHL = 4'd6;
    localparam logic [FUNC_W-1:0] F_SHR = 4'd7;
    localparam logic [FUNC_W-1:0] F_ASR = 4'd8;
    localparam logic [FUNC_W-1:0] F_MUL = 4'd9;

    localparam int unsigned FLG_Z = 0;
    localparam int unsigned FLG_N = 1;
    localparam int unsigned FLG_C = 2;
    localparam int unsigned FLG_V = 3;
    localparam int unsigned FLG_E = 4;

endpackage

// File: rtl/alu_if.sv
// CPU-side SPR window bus of the ALU: operand/function writes, result reads and the
// registered result, flags and valid bit.
interface alu_if;
    import alu_pkg::*;

    logic [1:0]        i_input_op;
    logic              i_data_valid;
    logic [WIDTH-1:0]  i_data;
    logic [1:0]        i_output_op;
    logic              i_result_empty;
    logic              o_result_valid;
    logic [WIDTH-1:0]  o_result;
    logic [FLAG_W-1:0] o_result_flags;

    modport master (
        output i_input_op, i_data_valid, i_data, i_output_op, i_result_empty,
        input  o_result_valid, o_result, o_result_flags
    );

    modport slave (
        input  i_input_op, i_data_valid, i_data, i_output_op, i_result_empty,
        output o_result_valid, o_result, o_result_flags
    );

endinterface

// File: rtl/alu_func.sv
// Purely combinational function unit: computes the low/high result words and the five
// status flags from the two operands and a function code.
module alu_func
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0]  opa_i,
    input  logic [WIDTH-1:0]  opb_i,
    input  logic [FUNC_W-1:0] func_i,
    output logic [WIDTH-1:0]  lo_o,
    output logic [WIDTH-1:0]  hi_o,
    output logic [FLAG_W-1:0] flags_o
);

    logic [4:0]        sh;
    logic [WIDTH:0]    sum;
    logic [WIDTH:0]    diff;
    logic [WIDTH:0]    shl_ext;
    logic [WIDTH:0]    shr_ext;
    logic signed [WIDTH:0] asr_ext;
    logic [2*WIDTH-1:0] prod;
    logic              carry;
    logic              ovf;

    assign sh   = opb_i[4:0];
    assign sum  = {1'b0, opa_i} + {1'b0, opb_i};
    assign diff = {1'b0, opa_i} - {1'b0, opb_i};
    assign prod = {{WIDTH{1'b0}}, opa_i} * {{WIDTH{1'b0}}, opb_i};

    // One guard bit catches the last bit shifted out; a zero shift leaves it clear.
    assign shl_ext = {1'b0, opa_i} << sh;
    assign shr_ext = {opa_i, 1'b0} >> sh;
    assign asr_ext = $signed({opa_i, 1'b0}) >>> sh;

    always_comb begin
        lo_o  = '0;
        hi_o  = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        unique case (func_i)
            F_ADD: begin
                lo_o  = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                hi_o  = {{(WIDTH-1){1'b0}}, carry};
                ovf   = (opa_i[WIDTH-1] == opb_i[WIDTH-1]) &&
                        (sum[WIDTH-1] != opa_i[WIDTH-1]);
            end
            F_SUB: begin
                lo_o  = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                hi_o  = {{(WIDTH-1){1'b0}}, carry};
                ovf   = (opa_i[WIDTH-1] != opb_i[WIDTH-1]) &&
                        (diff[WIDTH-1] != opa_i[WIDTH-1]);
            end
            F_AND: lo_o = opa_i & opb_i;
            F_OR:  lo_o = opa_i | opb_i;
            F_XOR: lo_o = opa_i ^ opb_i;
            F_NOT: lo_o = ~opa_i;
            F_SHL: begin
                lo_o  = shl_ext[WIDTH-1:0];
                carry = shl_ext[WIDTH];
            end
            F_SHR: begin
                lo_o  = shr_ext[WIDTH:1];
                carry = shr_ext[0];
            end
            F_ASR: begin
                lo_o  = asr_ext[WIDTH:1];
                carry = asr_ext[0];
            end
            F_MUL: begin
                lo_o  = prod[WIDTH-1:0];
                hi_o  = prod[2*WIDTH-1:WIDTH];
                carry = |prod[2*WIDTH-1:WIDTH];
            end
            default: ;
        endcase
    end

    always_comb begin
        flags_o        = '0;
        flags_o[FLG_Z] = (lo_o == '0);
        flags_o[FLG_N] = lo_o[WIDTH-1];
        flags_o[FLG_C] = carry;
        flags_o[FLG_V] = ovf;
        flags_o[FLG_E] = (opa_i == opb_i);
    end

endmodule

// File: rtl/alu.sv
// Transfer-triggered ALU top: operand/result registers, valid handshake and the
// combinational read-back mux of the SPR window.
module alu
    import alu_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst_n,
    alu_if.slave  bus
);

    logic [WIDTH-1:0]  opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [WIDTH-1:0]  res_lo_q, res_lo_d;
    logic [WIDTH-1:0]  res_hi_q, res_hi_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              valid_q, valid_d;

    logic [WIDTH-1:0]  fu_lo;
    logic [WIDTH-1:0]  fu_hi;
    logic [FLAG_W-1:0] fu_flags;
    logic              consume;

    alu_func u_func (
        .opa_i   (opa_q),
        .opb_i   (opb_q),
        .func_i  (bus.i_data[FUNC_W-1:0]),
        .lo_o    (fu_lo),
        .hi_o    (fu_hi),
        .flags_o (fu_flags)
    );

    assign consume = bus.i_result_empty &&
                     ((bus.i_output_op == OUT_RES) || (bus.i_output_op == OUT_HI));

    always_comb begin
        opa_d    = opa_q;
        opb_d    = opb_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        flags_d  = flags_q;
        valid_d  = valid_q;
        if (consume) begin
            valid_d = 1'b0;
        end
        // Writes are applied after the consume so a same-cycle launch or clear wins.
        if (bus.i_data_valid) begin
            unique case (bus.i_input_op)
                OP_OPA: opa_d = bus.i_data;
                OP_OPB: opb_d = bus.i_data;
                OP_FUNC: begin
                    res_lo_d = fu_lo;
                    res_hi_d = fu_hi;
                    flags_d  = fu_flags;
                    valid_d  = 1'b1;
                end
                OP_CLEAR: begin
                    opa_d    = '0;
                    opb_d    = '0;
                    res_lo_d = '0;
                    res_hi_d = '0;
                    flags_d  = '0;
                    valid_d  = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            opa_q    <= '0;
            opb_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            flags_q  <= flags_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        bus.o_result = res_lo_q;
        unique case (bus.i_output_op)
            OUT_RES: bus.o_result = res_lo_q;
            OUT_HI:  bus.o_result = res_hi_q;
            OUT_OPA: bus.o_result = opa_q;
            OUT_OPB: bus.o_result = opb_q;
            default: ;
        endcase
    end

    assign bus.o_result_valid = valid_q;
    assign bus.o_result_flags = flags_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the ALU: hand-computed results, flags and handshake
// behaviour, including an asynchronous reset while a result is pending.
module tb_alu;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    alu_if bus ();

    alu dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One qualified write, applied at the edge between two falling edges.
    task automatic wr(input logic [1:0] op, input logic [31:0] d);
        @(negedge clk);
        bus.i_input_op   = op;
        bus.i_data       = d;
        bus.i_data_valid = 1'b1;
        @(negedge clk);
        bus.i_data_valid = 1'b0;
    endtask

    task automatic rd(input logic [1:0] op, input string tag, input logic [31:0] exp);
        bus.i_output_op = op;
        #1;
        check_val(tag, bus.o_result, exp);
    endtask

    task automatic chk_state(input string tag, input logic valid, input logic [4:0] flags);
        #1;
        check_val({tag, ".valid"}, {31'd0, bus.o_result_valid}, {31'd0, valid});
        check_val({tag, ".flags"}, {27'd0, bus.o_result_flags}, {27'd0, flags});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        bus.i_input_op     = OP_OPA;
        bus.i_data_valid   = 1'b0;
        bus.i_data         = '0;
        bus.i_output_op    = OUT_RES;
        bus.i_result_empty = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_state("reset", 1'b0, 5'h00);
        rd(OUT_RES, "reset.res", 32'h0);
        rd(OUT_OPA, "reset.opa", 32'h0);
        rst_n = 1'b1;

        // ADD with carry out: Z|C
        wr(OP_OPA, 32'hFFFF_FFFF);
        wr(OP_OPB, 32'h0000_0001);
        chk_state("pre_launch", 1'b0, 5'h00);
        wr(OP_FUNC, 32'd0);
        chk_state("add", 1'b1, 5'h05);
        rd(OUT_RES, "add.lo", 32'h0);
        rd(OUT_HI,  "add.hi", 32'h1);
        rd(OUT_OPA, "add.opa", 32'hFFFF_FFFF);
        rd(OUT_OPB, "add.opb", 32'h1);

        // SUB signed overflow: V only; then equal operands: Z|E
        wr(OP_OPA, 32'h8000_0000);
        wr(OP_OPB, 32'h0000_0001);
        wr(OP_FUNC, 32'd1);
        chk_state("sub_ovf", 1'b1, 5'h08);
        rd(OUT_RES, "sub_ovf.lo", 32'h7FFF_FFFF);
        rd(OUT_HI,  "sub_ovf.hi", 32'h0);
        wr(OP_OPB, 32'h8000_0000);
        wr(OP_FUNC, 32'd1);
        chk_state("sub_eq", 1'b1, 5'h11);
        rd(OUT_RES, "sub_eq.lo", 32'h0);

        // SUB with borrow: 1 - 2 = 0xFFFFFFFF, N|C, hi=1
        wr(OP_OPA, 32'd1);
        wr(OP_OPB, 32'd2);
        wr(OP_FUNC, 32'd1);
        chk_state("sub_brw", 1'b1, 5'h06);
        rd(OUT_RES, "sub_brw.lo", 32'hFFFF_FFFF);
        rd(OUT_HI,  "sub_brw.hi", 32'h1);

        // MUL 0x10000 * 0x10000: Z|C|E
        wr(OP_OPA, 32'h0001_0000);
        wr(OP_OPB, 32'h0001_0000);
        wr(OP_FUNC, 32'd9);
        chk_state("mul", 1'b1, 5'h15);
        rd(OUT_RES, "mul.lo", 32'h0);
        rd(OUT_HI,  "mul.hi", 32'h1);

        // Shifts by B[4:0]=1 (B=0x21)
        wr(OP_OPA, 32'h8000_0001);
        wr(OP_OPB, 32'h0000_0021);
        wr(OP_FUNC, 32'd8);
        chk_state("asr", 1'b1, 5'h06);
        rd(OUT_RES, "asr.lo", 32'hC000_0000);
        wr(OP_FUNC, 32'd6);
        chk_state("shl", 1'b1, 5'h04);
        rd(OUT_RES, "shl.lo", 32'h0000_0002);
        wr(OP_FUNC, 32'd7);
        chk_state("shr", 1'b1, 5'h04);
        rd(OUT_RES, "shr.lo", 32'h4000_0000);

        // Logic ops: A=0xF0F0_00FF, B=0x0FF0_0F0F
        wr(OP_OPA, 32'hF0F0_00FF);
        wr(OP_OPB, 32'h0FF0_0F0F);
        wr(OP_FUNC, 32'd2);
        rd(OUT_RES, "and.lo", 32'h00F0_000F);
        wr(OP_FUNC, 32'd3);
        rd(OUT_RES, "or.lo", 32'hFFF0_0FFF);
        chk_state("or", 1'b1, 5'h02);
        wr(OP_FUNC, 32'd4);
        rd(OUT_RES, "xor.lo", 32'hFF00_0FF0);
        wr(OP_FUNC, 32'd5);
        rd(OUT_RES, "not.lo", 32'h0F0F_FF00);

        // Unused function code: zero result, flags still computed
        wr(OP_OPA, 32'd5);
        wr(OP_OPB, 32'd5);
        wr(OP_FUNC, 32'd12);
        chk_state("f12", 1'b1, 5'h11);
        rd(OUT_HI, "f12.hi", 32'h0);

        // Consume via OPA readback has no effect
        @(negedge clk);
        bus.i_output_op    = OUT_OPA;
        bus.i_result_empty = 1'b1;
        @(negedge clk);
        bus.i_result_empty = 1'b0;
        chk_state("nocons", 1'b1, 5'h11);

        // Consume via RESULT: valid drops, data retained
        wr(OP_OPA, 32'd7);
        wr(OP_OPB, 32'd3);
        wr(OP_FUNC, 32'd0);
        @(negedge clk);
        bus.i_output_op    = OUT_RES;
        bus.i_result_empty = 1'b1;
        @(negedge clk);
        bus.i_result_empty = 1'b0;
        chk_state("cons", 1'b0, 5'h00);
        rd(OUT_RES, "cons.lo", 32'd10);

        // Launch and consume in the same cycle: launch wins
        @(negedge clk);
        bus.i_output_op    = OUT_HI;
        bus.i_result_empty = 1'b1;
        bus.i_input_op     = OP_FUNC;
        bus.i_data         = 32'd1;
        bus.i_data_valid   = 1'b1;
        @(negedge clk);
        bus.i_result_empty = 1'b0;
        bus.i_data_valid   = 1'b0;
        chk_state("launch_cons", 1'b1, 5'h00);
        rd(OUT_RES, "launch_cons.lo", 32'd4);

        // CLEAR zeroes everything
        wr(OP_CLEAR, 32'd0);
        chk_state("clear", 1'b0, 5'h00);
        rd(OUT_RES, "clear.lo", 32'h0);
        rd(OUT_HI,  "clear.hi", 32'h0);
        rd(OUT_OPA, "clear.opa", 32'h0);
        rd(OUT_OPB, "clear.opb", 32'h0);

        // Asynchronous reset while a result is pending
        wr(OP_OPA, 32'h1234_5678);
        wr(OP_OPB, 32'h8765_4321);
        wr(OP_FUNC, 32'd3);
        chk_state("pre_rst", 1'b1, 5'h02);
        #1;
        rst_n = 1'b0;
        chk_state("async_rst", 1'b0, 5'h00);
        rd(OUT_RES, "async_rst.lo", 32'h0);
        rd(OUT_OPA, "async_rst.opa", 32'h0);
        rd(OUT_OPB, "async_rst.opb", 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
